// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the queued command payload.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    localparam int unsigned APB_CMD_W = $bits(apb_cmd_t);

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue feeding the APB FSM: first-word-fall-through, wrap-bit pointers,
// registered full/empty flags so the upstream ready has no path from the pop side.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 push,
    input  logic [APB_CMD_W-1:0] wr_cmd,
    input  logic                 pop,
    output logic [APB_CMD_W-1:0] rd_cmd,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    apb_cmd_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        if (do_push) begin
            wr_ptr_d = wr_ptr + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr + PTR_W'(1);
        end
    end

    // Flags are evaluated on the next pointers so they are plain flops.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            full   <= (wr_ptr_d[IDX_W] != rd_ptr_d[IDX_W]) &&
                      (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
            empty  <= (wr_ptr_d == rd_ptr_d);
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= wr_cmd;
        end
    end

    assign rd_cmd = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/apb_master.sv
// APB requester: drains the command queue onto APB and holds one response per command.
// Define APB_MASTER_TIMEOUT_EN to abandon transfers stuck in wait states for TIMEOUT_CYC cycles.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned CMD_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 16
)
(
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_mst_state_t state_q;
    apb_mst_state_t state_d;

    apb_cmd_t              cmd_in;
    apb_cmd_t              head;
    logic [APB_CMD_W-1:0]  fifo_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  slot_free;

    logic              psel_d;
    logic              penable_d;
    logic              pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        cmd_in.write = cmd_write;
        cmd_in.addr  = APB_ADDR_W'(cmd_addr);
        cmd_in.wdata = APB_DATA_W'(cmd_wdata);
    end

    apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .push    (cmd_valid),
        .wr_cmd  (cmd_in),
        .pop     (pop),
        .rd_cmd  (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head      = fifo_rd;
    assign cmd_ready = !fifo_full;
    // The slot may be refilled on the same edge it is drained.
    assign slot_free = !rsp_valid || rsp_ready;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        if (rsp_valid && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    state_d   = SETUP;
                    pop       = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = head.write;
                    paddr_d   = ADDR_W'(head.addr);
                    pwdata_d  = head.write ? DATA_W'(head.wdata) : '0;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // Abort on the edge where this wait cycle would make the count hit the limit.
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that drains a queue of simple read/write commands onto an APB bus and returns one response per command. It sits on the APB side of the AXI-to-APB bridge, between the AXI front end and the APB slave decoder. It drives PSEL/PENABLE/PWRITE/PADDR/PWDATA and samples PRDATA/PREADY/PSLVERR.

## Interface
- ADDR_W, 32, PADDR/cmd_addr width
- DATA_W, 32, PWDATA/PRDATA width
- CMD_DEPTH, 4, command FIFO entries; power of 2, ≥2
- TIMEOUT_CYC, 16, wait-state limit (used only with the timeout feature)

- PCLK  in  1  clock; every register is updated on the rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  = !fifo_full; registered-state only, no combinational path from cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address; driven unchanged onto PADDR
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response held
- rsp_ready  in  1  response accepted
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errored transfers
- rsp_err  out  1  PSLVERR was seen, or the transfer timed out
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  tie to 1 for zero-wait slaves
- PSLVERR  in  1  tie to 0 for slaves that do not report errors

## Operation
- **Command FIFO**
  - A command is pushed when cmd_valid && cmd_ready.
  - Commands execute strictly in order.
  - When the FIFO is full, cmd_ready = 0 even if an entry is popped in the same cycle.
- **FSM states:** IDLE, SETUP, ACCESS. All APB outputs are registered.
- **IDLE → SETUP** when the FIFO is non-empty and the response slot is free (!rsp_valid || rsp_ready). On this edge:
  - the command is popped;
  - PSEL = 1, PENABLE = 0;
  - PWRITE/PADDR/PWDATA are loaded from the command (PWDATA = 0 for reads).
- **SETUP → ACCESS** unconditionally; PENABLE = 1.
- **ACCESS, PREADY = 0:** stay in ACCESS. PSEL, PENABLE, PADDR, PWRITE and PWDATA stay stable.
- **ACCESS, PREADY = 1:** go to IDLE. On the same edge:
  - PSEL = PENABLE = 0;
  - rsp_valid = 1;
  - rsp_err = PSLVERR;
  - rsp_rdata = PRDATA if read and !PSLVERR, else 0.
- **After a transfer**
  - PADDR/PWRITE/PWDATA hold their last values.
  - ACCESS never goes directly to SETUP.
- **Response slot**
  - Holds exactly one response.
  - rsp_valid clears on rsp_valid && rsp_ready.
  - rsp_rdata/rsp_err are stable while rsp_valid && !rsp_ready.
  - A new SETUP is never started unless the slot will be free before that transfer completes.
- **Reset**
  - Values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata and rsp_err are all 0. FIFO is empty, state is IDLE, so cmd_ready = 1.
  - Reset mid-transfer drops PSEL/PENABLE immediately. Queued commands are discarded and no response is produced.

## Timing
- Push at edge E → PSEL high after edge E+1 (FIFO empty, slot free, state IDLE).
- Zero-wait transfer: SETUP 1 cycle, ACCESS 1 cycle. rsp_valid rises after the ACCESS edge.
- Throughput: at least 3 cycles per transfer (SETUP, ACCESS, IDLE). Each wait state adds 1 cycle.
- rsp_ready held 1 → back-to-back queued commands give PSEL high for 2 of every 3 cycles.

## Configuration
- **APB_MASTER_TIMEOUT_EN defined**
  - A counter of width $clog2(TIMEOUT_CYC+1) counts ACCESS cycles with PREADY = 0.
  - On the edge where the count reaches TIMEOUT_CYC with PREADY still 0, the transfer is abandoned: PSEL = PENABLE = 0, state goes to IDLE, and the response is rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - The counter clears on entry to SETUP.
  - If PREADY is 1 on the limit edge, the transfer completes normally.
- **Not defined:** no counter exists; ACCESS waits indefinitely for PREADY.

## Structure
- Package apb_pkg holds:
  - typedef apb_mst_state_t (IDLE, SETUP, ACCESS);
  - struct apb_cmd_t {write, addr, wdata};
  - localparam defaults for ADDR_W and DATA_W.
- One sub-module, apb_cmd_fifo:
  - synchronous FIFO of apb_cmd_t, depth CMD_DEPTH;
  - pointers with an extra wrap bit; full/empty outputs;
  - same PCLK/PRESETn.
- The FSM, response slot and optional timeout counter live in apb_master.

## Test plan
- Write 0xDEADBEEF to 0x0000_0008, PREADY = 1 → one SETUP cycle (PSEL = 1, PENABLE = 0, PWRITE = 1), then one ACCESS cycle, then rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Read 0x0000_0010, PREADY low for 3 ACCESS cycles then high with PRDATA = 0x12345678 → PENABLE high for 4 cycles with address stable; rsp_rdata = 0x12345678.
- CMD_DEPTH = 4, rsp_ready = 1, 6 commands offered back-to-back → cmd_ready drops once 4 are queued; all 6 are issued in order, 3 cycles apart; 6 responses in order.
- rsp_ready = 0 after the first response, second command queued → no SETUP until rsp_ready pulses; the first response stays stable throughout.
- PSLVERR = 1 on a read with PRDATA = 0xFFFF_FFFF → rsp_err = 1, rsp_rdata = 0. Separately, PRESETn low mid-ACCESS → PSEL/PENABLE go 0 asynchronously, FIFO empty, no response.
- APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYC = 16, PREADY held 0 → PSEL drops after 16 wait cycles; rsp_err = 1, rsp_rdata = 0; the next command proceeds. Without the macro, the same stimulus leaves ACCESS held indefinitely.
